// File: rtl/controlador_ram_dados.sv
// Data-RAM initiator: single load/store and multi-word copy/fill over 11x11 x 32-bit RAM.
// Latency load/store 2, fill N+1, copy 2N+1 cycles to pronto; req ignored while ocupado.
module controlador_ram_dados #(
  parameter int NUM_LINHAS  = 11,
  parameter int NUM_COLUNAS = 11,
  parameter int LARG_END    = 11
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_req,
  input  logic [1:0]          i_op,
  input  logic [LARG_END-1:0] i_orig_linha,
  input  logic [LARG_END-1:0] i_orig_coluna,
  input  logic [LARG_END-1:0] i_dest_linha,
  input  logic [LARG_END-1:0] i_dest_coluna,
  input  logic [LARG_END-1:0] i_quantidade,
  input  logic [31:0]         i_dado_cpu,
  output logic                o_ocupado,
  output logic                o_pronto,
  output logic                o_erro,
  output logic [31:0]         o_dado_lido,
  output logic [31:0]         o_ram_dados,
  output logic [LARG_END-1:0] o_ram_linha,
  output logic [LARG_END-1:0] o_ram_coluna,
  output logic                o_ram_write,
  input  logic [31:0]         i_ram_saida
);

  typedef enum logic [2:0] {
    OCIOSO, LE, ESCREVE, COPIA_LE, COPIA_ESCREVE, PREENCHE, FIM
  } estado_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [LARG_END-1:0] LIM_L = LARG_END'(NUM_LINHAS);
  localparam logic [LARG_END-1:0] LIM_C = LARG_END'(NUM_COLUNAS);
  localparam logic [LARG_END-1:0] ULT_C = LARG_END'(NUM_COLUNAS - 1);

  estado_t             r_estado, w_prox;
  logic [LARG_END-1:0] r_orig_linha, r_orig_coluna;
  logic [LARG_END-1:0] r_dest_linha, r_dest_coluna;
  logic [LARG_END-1:0] r_qtd;
  logic [31:0]         r_dado, r_buf, r_dado_lido;
  logic                r_erro;

  logic w_aceita, w_erro_set;
  logic w_orig_fora, w_dest_fora, w_fora_ini;
  logic w_orig_vira, w_dest_vira, w_orig_estoura, w_dest_estoura, w_ultima;

  assign w_orig_fora = (i_orig_linha >= LIM_L) || (i_orig_coluna >= LIM_C);
  assign w_dest_fora = (i_dest_linha >= LIM_L) || (i_dest_coluna >= LIM_C);
  assign w_fora_ini  = (((i_op == OP_LOAD) || (i_op == OP_COPY)) && w_orig_fora) ||
                       ((i_op != OP_LOAD) && w_dest_fora);

  // Row-wrap on the next word; overflow past the last row ends the burst with an error.
  assign w_orig_vira    = (r_orig_coluna == ULT_C);
  assign w_dest_vira    = (r_dest_coluna == ULT_C);
  assign w_orig_estoura = w_orig_vira && ((r_orig_linha + 1'b1) >= LIM_L);
  assign w_dest_estoura = w_dest_vira && ((r_dest_linha + 1'b1) >= LIM_L);
  assign w_ultima       = (r_qtd == LARG_END'(1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_estado <= OCIOSO;
    else         r_estado <= w_prox;
  end

  always_comb begin
    w_prox     = r_estado;
    w_aceita   = 1'b0;
    w_erro_set = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (i_req) begin
          w_aceita = 1'b1;
          if (w_fora_ini) begin
            w_prox     = FIM;
            w_erro_set = 1'b1;
          end else if (i_op[1] && (i_quantidade == '0)) begin
            w_prox = FIM;
          end else begin
            case (i_op)
              OP_LOAD:  w_prox = LE;
              OP_STORE: w_prox = ESCREVE;
              OP_COPY:  w_prox = COPIA_LE;
              default:  w_prox = PREENCHE;
            endcase
          end
        end
      end
      LE, ESCREVE: w_prox = FIM;
      COPIA_LE:    w_prox = COPIA_ESCREVE;
      COPIA_ESCREVE: begin
        if (w_ultima) begin
          w_prox = FIM;
        end else if (w_orig_estoura || w_dest_estoura) begin
          w_prox     = FIM;
          w_erro_set = 1'b1;
        end else begin
          w_prox = COPIA_LE;
        end
      end
      PREENCHE: begin
        if (w_ultima) begin
          w_prox = FIM;
        end else if (w_dest_estoura) begin
          w_prox     = FIM;
          w_erro_set = 1'b1;
        end
      end
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_orig_linha  <= '0;
      r_orig_coluna <= '0;
      r_dest_linha  <= '0;
      r_dest_coluna <= '0;
      r_qtd         <= '0;
      r_dado        <= '0;
      r_buf         <= '0;
      r_dado_lido   <= '0;
      r_erro        <= 1'b0;
    end else begin
      if (w_aceita) begin
        r_orig_linha  <= i_orig_linha;
        r_orig_coluna <= i_orig_coluna;
        r_dest_linha  <= i_dest_linha;
        r_dest_coluna <= i_dest_coluna;
        r_qtd         <= i_quantidade;
        r_dado        <= i_dado_cpu;
        r_erro        <= w_erro_set;
      end else if (w_erro_set) begin
        r_erro <= 1'b1;
      end
      case (r_estado)
        LE:       r_dado_lido <= i_ram_saida;
        COPIA_LE: r_buf       <= i_ram_saida;
        COPIA_ESCREVE: begin
          r_qtd         <= r_qtd - 1'b1;
          r_orig_coluna <= w_orig_vira ? '0 : r_orig_coluna + 1'b1;
          r_orig_linha  <= w_orig_vira ? r_orig_linha + 1'b1 : r_orig_linha;
          r_dest_coluna <= w_dest_vira ? '0 : r_dest_coluna + 1'b1;
          r_dest_linha  <= w_dest_vira ? r_dest_linha + 1'b1 : r_dest_linha;
        end
        PREENCHE: begin
          r_qtd         <= r_qtd - 1'b1;
          r_dest_coluna <= w_dest_vira ? '0 : r_dest_coluna + 1'b1;
          r_dest_linha  <= w_dest_vira ? r_dest_linha + 1'b1 : r_dest_linha;
        end
        default: ;
      endcase
    end
  end

  // RAM lines are decoded from state only, so an async reset drops ram_write at once.
  always_comb begin
    o_ram_linha  = '0;
    o_ram_coluna = '0;
    o_ram_dados  = '0;
    o_ram_write  = 1'b0;
    case (r_estado)
      LE, COPIA_LE: begin
        o_ram_linha  = r_orig_linha;
        o_ram_coluna = r_orig_coluna;
      end
      ESCREVE, PREENCHE: begin
        o_ram_linha  = r_dest_linha;
        o_ram_coluna = r_dest_coluna;
        o_ram_dados  = r_dado;
        o_ram_write  = 1'b1;
      end
      COPIA_ESCREVE: begin
        o_ram_linha  = r_dest_linha;
        o_ram_coluna = r_dest_coluna;
        o_ram_dados  = r_buf;
        o_ram_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_ocupado   = (r_estado != OCIOSO);
  assign o_pronto    = (r_estado == FIM);
  assign o_erro      = r_erro;
  assign o_dado_lido = r_dado_lido;

endmodule
